// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one 4-bit CLA group per stage,
// with operand skew and sum deskew so every bit of a result leaves together.
module cla_pipe_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             OVF,
  output logic             P,
  output logic             G
);

  localparam int NGRP = WIDTH / 4;

  typedef struct packed {
    logic [3:0] s;
    logic       cout;
    logic       c3;
    logic       gp;
    logic       gg;
  } grp_t;

  // Two-level lookahead inside one nibble; c3 is kept for the overflow flag.
  function automatic grp_t cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;
    grp_t       r;
    p    = a ^ b;
    g    = a & b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    r.gp = &p;
    r.gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    r.cout = r.gg | (r.gp & ci);
    r.c3 = c[3];
    r.s  = p ^ c;
    return r;
  endfunction

  logic             vld_q [NGRP];
  logic [WIDTH-1:0] a_q   [NGRP];
  logic [WIDTH-1:0] b_q   [NGRP];
  logic [WIDTH-1:0] s_q   [NGRP];
  logic             c_q   [NGRP];
  logic             ovf_q [NGRP];
  logic             p_q   [NGRP];
  logic             g_q   [NGRP];

  logic             src_v [NGRP];
  logic [WIDTH-1:0] src_a [NGRP];
  logic [WIDTH-1:0] src_b [NGRP];
  logic [WIDTH-1:0] src_s [NGRP];
  logic             src_c [NGRP];
  logic             src_p [NGRP];
  logic             src_g [NGRP];

  grp_t             grp   [NGRP];
  logic [WIDTH-1:0] s_d   [NGRP];
  logic             ovf_d [NGRP];
  logic             p_d   [NGRP];
  logic             g_d   [NGRP];

  logic stall;

  assign out_valid = vld_q[NGRP-1];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

  // Stage 0 takes the ports (B inverted and carry forced to 1 for subtract);
  // later stages take the previous stage's registers.
  always_comb begin
    src_v[0] = in_valid;
    src_a[0] = A;
    src_b[0] = sub ? ~B : B;
    src_s[0] = '0;
    src_c[0] = sub | Cin;
    src_p[0] = 1'b1;
    src_g[0] = 1'b0;
    for (int k = 1; k < NGRP; k++) begin
      src_v[k] = vld_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
      src_c[k] = c_q[k-1];
      src_p[k] = p_q[k-1];
      src_g[k] = g_q[k-1];
    end
    for (int k = 0; k < NGRP; k++) begin
      grp[k]             = cla4(src_a[k][4*k +: 4], src_b[k][4*k +: 4], src_c[k]);
      s_d[k]             = src_s[k];
      s_d[k][4*k +: 4]   = grp[k].s;
      ovf_d[k]           = grp[k].c3 ^ grp[k].cout;
      p_d[k]             = src_p[k] & grp[k].gp;
      g_d[k]             = grp[k].gg | (grp[k].gp & src_g[k]);
    end
  end

  // Valid bits reset; data registers only need to advance whenever the pipe moves.
  for (genvar k = 0; k < NGRP; k++) begin : g_stage
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q[k] <= 1'b0;
      end else if (!stall) begin
        vld_q[k] <= src_v[k];
      end
    end

    always_ff @(posedge clk) begin
      if (!stall) begin
        a_q[k]   <= src_a[k];
        b_q[k]   <= src_b[k];
        s_q[k]   <= s_d[k];
        c_q[k]   <= grp[k].cout;
        ovf_q[k] <= ovf_d[k];
        p_q[k]   <= p_d[k];
        g_q[k]   <= g_d[k];
      end
    end
  end

  assign S    = s_q[NGRP-1];
  assign Cout = c_q[NGRP-1];
  assign OVF  = ovf_q[NGRP-1];
  assign P    = p_q[NGRP-1];
  assign G    = g_q[NGRP-1];

endmodule

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand width; legal values are multiples of 4 from 4 to 64.
REQ-002 The block SHALL have derived localparam NGRP = WIDTH/4, meaning the number of 4-bit CLA groups, which is also the pipeline depth.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operand beat offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the beat this cycle.
REQ-007 The block SHALL have ports A and B, input, WIDTH bits each: operands.
REQ-008 The block SHALL have port Cin, input, 1 bit: carry in; ignored when sub=1.
REQ-009 The block SHALL have port sub, input, 1 bit: 0 selects A+B+Cin; 1 selects A-B, computed as A+~B+1.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result beat present.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 The block SHALL have port S, output, WIDTH bits: sum.
REQ-013 The block SHALL have port Cout, output, 1 bit: carry out of the MSB.
REQ-014 The block SHALL have port OVF, output, 1 bit: two's-complement overflow, equal to the carry into the MSB XOR Cout.
REQ-015 The block SHALL have ports P and G, output, 1 bit each: whole-word propagate and generate, formed as the lookahead combination of all group P/G.

Function
REQ-016 Stage k (k=0..NGRP-1) SHALL compute group k bits [4k+3:4k] as a 4-bit CLA, using the carry registered by stage k-1; stage 0 SHALL use Cin, or 1 when sub=1.
REQ-017 Operand bits for groups above k SHALL travel through skew registers alongside the beat, and lower sum bits SHALL travel through deskew registers, so all of S appears in the same cycle.
REQ-018 Latency SHALL be exactly NGRP cycles from the accepting edge (in_valid & in_ready) to out_valid=1 with that beat's result, when out_ready stays 1.
REQ-019 Throughput SHALL be one beat per cycle with no bubbles while out_ready=1.
REQ-020 Each stage SHALL hold a valid bit; the stall condition is stall = out_valid & ~out_ready.
REQ-021 in_ready SHALL equal ~stall, combinationally.
REQ-022 While stall=1, every stage register (data and valid) SHALL hold its value.
REQ-023 While stall=0, every stage SHALL advance by one stage; stage 0 SHALL load valid = in_valid.
REQ-024 Bubbles (valid=0) SHALL advance without being compressed; no squeeze-out is required.
REQ-025 S, Cout, OVF, P and G SHALL be registered outputs of the last stage, held stable while out_valid=1 and out_ready=0.
REQ-026 Output values while out_valid=0 SHALL be don't-care; the bench SHALL check them only when out_valid=1.
REQ-027 The result SHALL be the modulo-2^WIDTH sum; there SHALL be no saturation.
REQ-028 Cout SHALL be the true carry, so for sub=1, Cout=1 means no borrow (A >= B, unsigned).
REQ-029 Beats in flight SHALL carry their own sub/Cin; mixing modes back-to-back SHALL be legal.

Reset
REQ-030 While reset=1 at a clock edge, all stage valid bits SHALL clear; out_valid SHALL be 0 and in_ready SHALL be 1 the next cycle.
REQ-031 Reset SHALL take priority over stall and over in_valid.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight beats without emitting them.
REQ-033 Data registers need not be reset.
REQ-034 The first beat may be accepted on the first edge after reset deasserts.

Verification (WIDTH=16, NGRP=4)
REQ-035 Bench SHALL apply A=0x00FF, B=0x0001, Cin=0, sub=0 at cycle 0 -> out_valid at cycle 4 with S=0x0100, Cout=0, OVF=0.
REQ-036 Bench SHALL apply A=0xFFFF, B=0xFFFF, Cin=1 -> S=0xFFFF, Cout=1, P=0, G=1.
REQ-037 Bench SHALL apply sub=1 with A=0x8000, B=0x0001 -> S=0x7FFF, Cout=1, OVF=1; and sub=1 with A=0x0003, B=0x0005 -> S=0xFFFE, Cout=0.
REQ-038 Bench SHALL stream 8 back-to-back beats while out_ready=0 for cycles 5-7 -> in_ready=0 during those cycles, outputs hold, all 8 results in order with none lost or duplicated.
REQ-039 Bench SHALL assert reset for 1 cycle with 3 beats in flight -> no out_valid for the next 4 cycles, and the next accepted beat emerges 4 cycles later.
REQ-040 Bench SHALL run an exhaustive sweep at WIDTH=4 (A, B, Cin, sub: 1024 beats) plus 10000 random beats at WIDTH=32, with a scoreboard comparing against A+B+Cin / A-B including Cout and OVF.
